ar_arbiter: RTL and testbench

Arbitrates two AXI masters (M0, M1) onto the single shared read-address channel that feeds the AR address decoder. It selects one requester with round-robin fairness and holds the grant until the downstream AR handshake completes. It prefixes a 4-bit master tag to ARID. It also enforces a per-master outstanding-read limit by counting accepted AR transfers against returning RLAST beats.

---
 rtl/ar_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_ar_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ar_arbiter.sv
// Two-master AXI read-address arbiter: round-robin grant held until the AR handshake,
// master tag prefixed to ARID, per-master outstanding-read limit. Option macro: AR_ARB_FIXED_PRIO_EN.

`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

module ar_arbiter #(
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = 4
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    input  logic [`AXI_ID_BITS-1:0]     ARID_M0,
    input  logic [`AXI_ADDR_BITS-1:0]   ARADDR_M0,
    input  logic [`AXI_LEN_BITS-1:0]    ARLEN_M0,
    input  logic [`AXI_SIZE_BITS-1:0]   ARSIZE_M0,
    input  logic [1:0]                  ARBURST_M0,
    input  logic                        ARVALID_M0,
    output logic                        ARREADY_M0,
    input  logic [`AXI_ID_BITS-1:0]     ARID_M1,
    input  logic [`AXI_ADDR_BITS-1:0]   ARADDR_M1,
    input  logic [`AXI_LEN_BITS-1:0]    ARLEN_M1,
    input  logic [`AXI_SIZE_BITS-1:0]   ARSIZE_M1,
    input  logic [1:0]                  ARBURST_M1,
    input  logic                        ARVALID_M1,
    output logic                        ARREADY_M1,
    output logic [`AXI_ID_BITS+3:0]     ARID,
    output logic [`AXI_ADDR_BITS-1:0]   ARADDR,
    output logic [`AXI_LEN_BITS-1:0]    ARLEN,
    output logic [`AXI_SIZE_BITS-1:0]   ARSIZE,
    output logic [1:0]                  ARBURST,
    output logic                        ARVALID,
    input  logic                        ARREADY,
    input  logic [`AXI_ID_BITS+3:0]     RID,
    input  logic                        RVALID,
    input  logic                        RREADY,
    input  logic                        RLAST
);

    localparam int ID_W = `AXI_ID_BITS;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);
    localparam logic [3:0] TAG_M0 = 4'b0001;
    localparam logic [3:0] TAG_M1 = 4'b0010;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] GRANT_M0 = 2'd1;
    localparam logic [1:0] GRANT_M1 = 2'd2;

    logic [1:0]            state_reg, state_next;
    logic                  last_grant_reg, last_grant_next;  // 1'b1 means M1 was granted last
    logic [1:0]            arvalid_m;
    logic [1:0]            elig;
    logic [1:0]            hs;
    logic [1:0]            dec;
    logic [1:0][CNT_W-1:0] cnt;
    logic [CNT_W-1:0]      cnt_m0;
    logic [CNT_W-1:0]      cnt_m1;
    logic [3:0]            rtag;
    logic                  r_done;

    assign arvalid_m = {ARVALID_M1, ARVALID_M0};
    assign rtag      = RID[ID_W+3 -: 4];
    assign r_done    = RVALID && RREADY && RLAST;
    assign dec[0]    = r_done && (rtag == TAG_M0);
    assign dec[1]    = r_done && (rtag == TAG_M1);
    assign hs[0]     = (state_reg == GRANT_M0) && ARVALID_M0 && ARREADY;
    assign hs[1]     = (state_reg == GRANT_M1) && ARVALID_M1 && ARREADY;
    assign cnt_m0    = cnt[0];
    assign cnt_m1    = cnt[1];

    // Per-master outstanding counter; a same-cycle accept and completion cancel out.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_cnt
            logic [CNT_W-1:0] cnt_reg, cnt_next;

            always_comb begin
                cnt_next = cnt_reg;
                if (hs[gi] && dec[gi]) begin
                    cnt_next = cnt_reg;
                end else if (hs[gi]) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end else if (dec[gi] && (cnt_reg != '0)) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end

            always_ff @(posedge ACLK or negedge ARESETn) begin
                if (!ARESETn) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign cnt[gi]  = cnt_reg;
            assign elig[gi] = arvalid_m[gi] && (cnt_reg != MAX_CNT);
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            IDLE: begin
                if (elig[0] && elig[1]) begin
`ifdef AR_ARB_FIXED_PRIO_EN
                    state_next = GRANT_M0;
`else
                    state_next = last_grant_reg ? GRANT_M0 : GRANT_M1;
`endif
                end else if (elig[0]) begin
                    state_next = GRANT_M0;
                end else if (elig[1]) begin
                    state_next = GRANT_M1;
                end
            end
            GRANT_M0: begin
                if (hs[0]) begin
                    state_next      = IDLE;
                    last_grant_next = 1'b0;
                end
            end
            GRANT_M1: begin
                if (hs[1]) begin
                    state_next      = IDLE;
                    last_grant_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
        end
    end

    // Payload is a pure mux off the registered grant, so it is zero in IDLE.
    always_comb begin
        ARVALID    = 1'b0;
        ARID       = '0;
        ARADDR     = '0;
        ARLEN      = '0;
        ARSIZE     = '0;
        ARBURST    = '0;
        ARREADY_M0 = 1'b0;
        ARREADY_M1 = 1'b0;
        case (state_reg)
            GRANT_M0: begin
                ARVALID    = ARVALID_M0;
                ARID       = {TAG_M0, ARID_M0};
                ARADDR     = ARADDR_M0;
                ARLEN      = ARLEN_M0;
                ARSIZE     = ARSIZE_M0;
                ARBURST    = ARBURST_M0;
                ARREADY_M0 = ARREADY;
            end
            GRANT_M1: begin
                ARVALID    = ARVALID_M1;
                ARID       = {TAG_M1, ARID_M1};
                ARADDR     = ARADDR_M1;
                ARLEN      = ARLEN_M1;
                ARSIZE     = ARSIZE_M1;
                ARBURST    = ARBURST_M1;
                ARREADY_M1 = ARREADY;
            end
            default: ;
        endcase
    end

    logic unused_sig;
`ifdef AR_ARB_FIXED_PRIO_EN
    assign unused_sig = &{1'b0, RID[ID_W-1:0], last_grant_reg};
`else
    assign unused_sig = &{1'b0, RID[ID_W-1:0]};
`endif

endmodule

// File: tb/tb_ar_arbiter.sv
// Directed and randomized bench for ar_arbiter against a transaction-level grant/count model.

`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

module tb_ar_arbiter;
    localparam int IDW = `AXI_ID_BITS;
    localparam int AW  = `AXI_ADDR_BITS;
    localparam int LW  = `AXI_LEN_BITS;
    localparam int SW  = `AXI_SIZE_BITS;
    localparam int MAXO = 4;

    logic ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    logic            ARESETn;
    logic [1:0]      arvalid_m;
    logic [IDW-1:0]  arid_m    [2];
    logic [AW-1:0]   araddr_m  [2];
    logic [LW-1:0]   arlen_m   [2];
    logic [SW-1:0]   arsize_m  [2];
    logic [1:0]      arburst_m [2];
    logic            ARREADY_M0, ARREADY_M1;
    logic [IDW+3:0]  ARID;
    logic [AW-1:0]   ARADDR;
    logic [LW-1:0]   ARLEN;
    logic [SW-1:0]   ARSIZE;
    logic [1:0]      ARBURST;
    logic            ARVALID;
    logic            ARREADY;
    logic [IDW+3:0]  RID;
    logic            RVALID, RREADY, RLAST;

    ar_arbiter #(.MAX_OUTST(MAXO), .CNT_W(4)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID_M0(arid_m[0]), .ARADDR_M0(araddr_m[0]), .ARLEN_M0(arlen_m[0]),
        .ARSIZE_M0(arsize_m[0]), .ARBURST_M0(arburst_m[0]), .ARVALID_M0(arvalid_m[0]),
        .ARREADY_M0(ARREADY_M0),
        .ARID_M1(arid_m[1]), .ARADDR_M1(araddr_m[1]), .ARLEN_M1(arlen_m[1]),
        .ARSIZE_M1(arsize_m[1]), .ARBURST_M1(arburst_m[1]), .ARVALID_M1(arvalid_m[1]),
        .ARREADY_M1(ARREADY_M1),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who holds the grant (-1 = nobody), who won last, burst counts.
    int m_gnt;
    int m_last;
    int m_cnt [2];
    int m_hs  [2];
    int obs_log [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_gnt = -1;
        m_last = 1;
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_hs[0] = 0;  m_hs[1] = 0;
    endtask

    task automatic model_update();
        int ng;
        int dc [2];
        logic [3:0] tag;
        tag = RID[IDW+3 -: 4];
        dc[0] = (RVALID && RREADY && RLAST && tag == 4'b0001) ? 1 : 0;
        dc[1] = (RVALID && RREADY && RLAST && tag == 4'b0010) ? 1 : 0;
        m_hs[0] = 0; m_hs[1] = 0;
        if (m_gnt >= 0 && arvalid_m[m_gnt] && ARREADY) m_hs[m_gnt] = 1;
        ng = m_gnt;
        if (m_gnt < 0) begin
            bit e0, e1;
            e0 = arvalid_m[0] && (m_cnt[0] != MAXO);
            e1 = arvalid_m[1] && (m_cnt[1] != MAXO);
`ifdef AR_ARB_FIXED_PRIO_EN
            if (e0) ng = 0; else if (e1) ng = 1;
`else
            if (e0 && e1) ng = 1 - m_last; else if (e0) ng = 0; else if (e1) ng = 1;
`endif
        end else if (m_hs[m_gnt] != 0) begin
            m_last = m_gnt;
            ng = -1;
        end
        for (int m = 0; m < 2; m++) begin
            if (m_hs[m] != 0 && dc[m] != 0) m_cnt[m] = m_cnt[m];
            else if (m_hs[m] != 0) m_cnt[m]++;
            else if (dc[m] != 0 && m_cnt[m] > 0) m_cnt[m]--;
        end
        m_gnt = ng;
    endtask

    task automatic settle_check();
        logic            e_v, e_r0, e_r1;
        logic [IDW+3:0]  e_id;
        logic [AW-1:0]   e_addr;
        logic [LW-1:0]   e_len;
        logic [SW-1:0]   e_size;
        logic [1:0]      e_burst;
        #1;
        e_v = 1'b0; e_r0 = 1'b0; e_r1 = 1'b0;
        e_id = '0; e_addr = '0; e_len = '0; e_size = '0; e_burst = '0;
        if (m_gnt >= 0) begin
            e_v     = arvalid_m[m_gnt];
            e_id    = {(m_gnt == 0) ? 4'b0001 : 4'b0010, arid_m[m_gnt]};
            e_addr  = araddr_m[m_gnt];
            e_len   = arlen_m[m_gnt];
            e_size  = arsize_m[m_gnt];
            e_burst = arburst_m[m_gnt];
            if (m_gnt == 0) e_r0 = ARREADY; else e_r1 = ARREADY;
        end
        chk("arvalid", 64'(ARVALID), 64'(e_v));
        chk("arid", 64'(ARID), 64'(e_id));
        chk("araddr", 64'(ARADDR), 64'(e_addr));
        chk("arlen", 64'(ARLEN), 64'(e_len));
        chk("arsize", 64'(ARSIZE), 64'(e_size));
        chk("arburst", 64'(ARBURST), 64'(e_burst));
        chk("arready_m0", 64'(ARREADY_M0), 64'(e_r0));
        chk("arready_m1", 64'(ARREADY_M1), 64'(e_r1));
        chk("cnt_m0", 64'(dut.cnt_m0), 64'(m_cnt[0]));
        chk("cnt_m1", 64'(dut.cnt_m1), 64'(m_cnt[1]));
        if (ARVALID && ARREADY && ARREADY_M0) obs_log.push_back(0);
        if (ARVALID && ARREADY && ARREADY_M1) obs_log.push_back(1);
    endtask

    task automatic advance();
        if (ARESETn) model_update();
        @(negedge ACLK);
    endtask

    task automatic step();
        if (!ARESETn) model_reset();
        settle_check();
        advance();
    endtask

    task automatic clear_inputs();
        arvalid_m = 2'b00;
        ARREADY = 1'b0;
        RVALID = 1'b0; RREADY = 1'b0; RLAST = 1'b0; RID = '0;
    endtask

    task automatic rand_payload(input int m);
        arid_m[m]    = IDW'($urandom);
        araddr_m[m]  = AW'($urandom);
        arlen_m[m]   = LW'($urandom);
        arsize_m[m]  = SW'($urandom);
        arburst_m[m] = 2'($urandom);
    endtask

    task automatic do_reset();
        clear_inputs();
        ARESETn = 1'b0;
        step();
        ARESETn = 1'b1;
        obs_log.delete();
    endtask

    function automatic int count_of(input int m);
        int n = 0;
        foreach (obs_log[i]) if (obs_log[i] == m) n++;
        return n;
    endfunction

    initial begin
        ARESETn = 1'b0;
        clear_inputs();
        rand_payload(0); rand_payload(1);
        model_reset();
        @(negedge ACLK);
        step();
        chk("reset_arvalid", 64'(ARVALID), 64'd0);
        ARESETn = 1'b1;

        // Single M0 request: ARVALID one cycle later with tagged ID.
        arvalid_m[0] = 1'b1; araddr_m[0] = 32'h0000_1000; arid_m[0] = IDW'(3); ARREADY = 1'b1;
        settle_check();
        chk("t1_idle_first", 64'(ARVALID), 64'd0);
        advance();
        settle_check();
        chk("t1_arvalid", 64'(ARVALID), 64'd1);
        chk("t1_arid", 64'(ARID), 64'({4'b0001, IDW'(3)}));
        chk("t1_arready_m0", 64'(ARREADY_M0), 64'd1);
        advance();
        arvalid_m[0] = 1'b0;
        settle_check();
        chk("t1_cnt_m0", 64'(dut.cnt_m0), 64'd1);
        chk("t1_back_idle", 64'(ARVALID), 64'd0);
        advance();
        $display("T1 single M0 request done");

        // Both masters continuously requesting.
        do_reset();
        arvalid_m = 2'b11; ARREADY = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("t2_grants", 64'(obs_log.size()), 64'd4);
        if (obs_log.size() == 4) begin
`ifdef AR_ARB_FIXED_PRIO_EN
            chk("t2_order", 64'({obs_log[0][3:0], obs_log[1][3:0], obs_log[2][3:0], obs_log[3][3:0]}), 64'h0000);
`else
            chk("t2_order", 64'({obs_log[0][3:0], obs_log[1][3:0], obs_log[2][3:0], obs_log[3][3:0]}), 64'h0101);
`endif
        end
        $display("T2 contention order done");

        // M1 granted and stalled by ARREADY for 5 cycles.
        do_reset();
        rand_payload(1);
        arvalid_m[1] = 1'b1;
        step();
        arvalid_m[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle_check();
            chk("t3_stall_valid", 64'(ARVALID), 64'd1);
            chk("t3_stall_addr", 64'(ARADDR), 64'(araddr_m[1]));
            chk("t3_stall_rdy_m0", 64'(ARREADY_M0), 64'd0);
            advance();
        end
        ARREADY = 1'b1;
        settle_check();
        chk("t3_hs_m1", 64'(ARREADY_M1), 64'd1);
        advance();
        arvalid_m = 2'b00;
        step();
        $display("T3 stalled M1 grant done");

        // Outstanding limit on M0 while M1 is kept drained by its own RLASTs.
        do_reset();
        arvalid_m = 2'b11; ARREADY = 1'b1;
        RVALID = 1'b1; RREADY = 1'b1; RLAST = 1'b1; RID = {4'b0010, IDW'(0)};
        for (int i = 0; i < 16; i++) step();
        chk("t4_cnt_m0_full", 64'(dut.cnt_m0), 64'(MAXO));
        obs_log.delete();
        for (int i = 0; i < 8; i++) step();
        chk("t4_m0_blocked", 64'(count_of(0)), 64'd0);
        chk("t4_m1_served", 64'(count_of(1) > 0), 64'd1);
        RID = {4'b0001, IDW'(5)};
        step();
        RLAST = 1'b0;
        settle_check();
        chk("t4_cnt_m0_dec", 64'(dut.cnt_m0), 64'(MAXO - 1));
        advance();
        obs_log.delete();
        for (int i = 0; i < 6; i++) step();
        chk("t4_m0_regranted", 64'(count_of(0) > 0), 64'd1);
        $display("T4 outstanding limit done");

        // Simultaneous accept and completion, foreign tag, completion at zero.
        do_reset();
        arvalid_m[0] = 1'b1; ARREADY = 1'b1;
        for (int i = 0; i < 4; i++) step();
        ARREADY = 1'b0;
        step();
        ARREADY = 1'b1; RVALID = 1'b1; RREADY = 1'b1; RLAST = 1'b1; RID = {4'b0001, IDW'(1)};
        step();
        clear_inputs();
        settle_check();
        chk("t5_same_cycle", 64'(dut.cnt_m0), 64'd2);
        advance();
        RVALID = 1'b1; RREADY = 1'b1; RLAST = 1'b1; RID = {4'b0100, IDW'(1)};
        step();
        clear_inputs();
        settle_check();
        chk("t5_other_tag", 64'(dut.cnt_m0), 64'd2);
        advance();
        do_reset();
        RVALID = 1'b1; RREADY = 1'b1; RLAST = 1'b1; RID = {4'b0001, IDW'(2)};
        step();
        clear_inputs();
        settle_check();
        chk("t5_no_underflow", 64'(dut.cnt_m0), 64'd0);
        advance();
        $display("T5 counter corner cases done");

        // Asynchronous reset in the middle of a GRANT_M0.
        do_reset();
        arvalid_m[1] = 1'b1; ARREADY = 1'b1;
        step(); step();
        arvalid_m[1] = 1'b0; arvalid_m[0] = 1'b1; ARREADY = 1'b0;
        step(); step();
        #2;
        ARESETn = 1'b0; ARREADY = 1'b1;
        model_reset();
        #1;
        chk("t6_arvalid_async", 64'(ARVALID), 64'd0);
        chk("t6_arready_m0_async", 64'(ARREADY_M0), 64'd0);
        chk("t6_cnt_m1_cleared", 64'(dut.cnt_m1), 64'd0);
        @(negedge ACLK);
        ARESETn = 1'b1; arvalid_m = 2'b11;
        obs_log.delete();
        step(); step();
        chk("t6_first_after_reset", 64'((obs_log.size() > 0) ? obs_log[0] : 9), 64'd0);
        $display("T6 mid-grant reset done");

        // Randomized traffic; masters keep ARVALID and payload until accepted.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!arvalid_m[m] || m_hs[m] != 0) begin
                    arvalid_m[m] = ($urandom_range(0, 2) != 0);
                    rand_payload(m);
                end
            end
            ARREADY = ($urandom_range(0, 3) != 0);
            RVALID  = ($urandom_range(0, 1) != 0);
            RREADY  = ($urandom_range(0, 3) != 0);
            RLAST   = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0, 1:    RID = {4'b0001, IDW'($urandom)};
                2, 3:    RID = {4'b0010, IDW'($urandom)};
                4:       RID = {4'b0100, IDW'($urandom)};
                default: RID = {4'b0000, IDW'($urandom)};
            endcase
            step();
        end
        $display("T7 random traffic done, grants observed %0d", obs_log.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
